// File: rtl/jk_latch_driver.sv
// jk_latch_driver: initiator for a bank of level-enabled JK latches.
// Takes a target word over a valid/ready handshake, derives set/reset-only
// J/K excitation from the present Q, pulses en for one cycle, waits
// SETTLE_CYCLES, then compares Q against the target and reports the result.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE while rst is low.
// req_valid/req_target are ignored at every other edge and nothing is queued.
//
// Optional build macro JK_DRV_RETRY_EN: a failed check re-drives the bank
// up to MAX_RETRY more times before reporting done.
module jk_latch_driver #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             en,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             match,
    output logic [WIDTH-1:0] err_mask,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SETTLE = 2'd2,
        S_CHECK  = 2'd3
    } state_t;

    // Reject out-of-range parameters at elaboration.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 1..255");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_retry
        $error("MAX_RETRY out of range 0..15");
    end

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] target, target_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt, err_nxt;
    logic             en_nxt, done_nxt, match_nxt;
`ifdef JK_DRV_RETRY_EN
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
    logic [3:0] retry, retry_nxt;
`endif

    assign req_ready = (state == S_IDLE) && !rst;
    assign state_dbg = state;

    // Register FSM state and all registered outputs; reset abandons any request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            target   <= '0;
            cnt      <= '0;
            j        <= '0;
            k        <= '0;
            en       <= 1'b0;
            done     <= 1'b0;
            match    <= 1'b0;
            err_mask <= '0;
`ifdef JK_DRV_RETRY_EN
            retry    <= '0;
`endif
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            cnt      <= cnt_nxt;
            j        <= j_nxt;
            k        <= k_nxt;
            en       <= en_nxt;
            done     <= done_nxt;
            match    <= match_nxt;
            err_mask <= err_nxt;
`ifdef JK_DRV_RETRY_EN
            retry    <= retry_nxt;
`endif
        end
    end

    // Next-state and output decode. Excitation only ever sets (j) or resets (k)
    // a bit; j=k=1 would toggle repeatedly while the level enable is open.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        cnt_nxt    = cnt;
        j_nxt      = '0;
        k_nxt      = '0;
        en_nxt     = 1'b0;
        done_nxt   = 1'b0;
        match_nxt  = match;
        err_nxt    = err_mask;
`ifdef JK_DRV_RETRY_EN
        retry_nxt  = retry;
`endif
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    target_nxt = req_target;
                    j_nxt      = ~q_fb & req_target;
                    k_nxt      = q_fb & ~req_target;
                    en_nxt     = 1'b1;
                    state_nxt  = S_DRIVE;
`ifdef JK_DRV_RETRY_EN
                    retry_nxt  = '0;
`endif
                end
            end
            S_DRIVE: begin
                cnt_nxt   = SETTLE_LOAD;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_CHECK;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_CHECK: begin
`ifdef JK_DRV_RETRY_EN
                if ((q_fb != target) && (retry < RETRY_LIMIT)) begin
                    retry_nxt = retry + 4'd1;
                    j_nxt     = ~q_fb & target;
                    k_nxt     = q_fb & ~target;
                    en_nxt    = 1'b1;
                    state_nxt = S_DRIVE;
                end else begin
                    done_nxt  = 1'b1;
                    match_nxt = (q_fb == target);
                    err_nxt   = q_fb ^ target;
                    state_nxt = S_IDLE;
                end
`else
                done_nxt  = 1'b1;
                match_nxt = (q_fb == target);
                err_nxt   = q_fb ^ target;
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jk_latch_driver.sv
// Testbench for jk_latch_driver with a behavioural JK latch bank model.
module tb_jk_latch_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_target;
    logic [W-1:0] j, k, q_fb;
    logic         en, done, match;
    logic [W-1:0] err_mask;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock: 10 ns period, DUT active on rising edge.
    always #5 clk = ~clk;

    jk_latch_driver #(.WIDTH(W), .SETTLE_CYCLES(2), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_target(req_target), .j(j), .k(k), .en(en), .q_fb(q_fb),
        .done(done), .match(match), .err_mask(err_mask), .state_dbg(state_dbg)
    );

    // Latch bank model: transparent while en is high (updated mid-cycle);
    // bits in 'stuck' can never be set. 'load' presets Q directly.
    logic [W-1:0] q_lat, stuck, load_val;
    logic         load;
    always @(negedge clk) begin
        if (load) q_lat <= load_val;
        else if (en) q_lat <= ((q_lat & ~k) | j) & ~stuck;
    end
    assign q_fb = q_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Preset the latch bank; call #1 after a rising edge.
    task automatic preset_q(input logic [W-1:0] v);
        load = 1'b1;
        load_val = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Wait for done after a transfer (call #1 after the transfer edge).
    // lat = edges from transfer to done; pulses = extra en pulses seen.
    task automatic wait_done(output int lat, output int pulses, input int unstick_at);
        lat = 0;
        pulses = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (en) pulses++;
            if (lat == unstick_at) stuck = '0;
        end while (!done && lat < 40);
    endtask

    // One complete request from IDLE; call #1 after a rising edge.
    task automatic run_req(input string tag, input logic [W-1:0] t,
                           input logic [W-1:0] exp_j, input logic [W-1:0] exp_k,
                           input int exp_lat, input int exp_pulses,
                           input logic exp_match, input logic [W-1:0] exp_err,
                           input int unstick_at);
        int lat, pul;
        check({tag, "_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_target = t;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, "_en"}, en, 1'b1);
        check({tag, "_j"}, j, exp_j);
        check({tag, "_k"}, k, exp_k);
        wait_done(lat, pul, unstick_at);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_pulses"}, 1 + pul, exp_pulses);
        check({tag, "_match"}, match, exp_match);
        check({tag, "_err"}, err_mask, exp_err);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, done, 1'b0);
        check({tag, "_err_hold"}, err_mask, exp_err);
    endtask

    initial begin
        int lat, pul, dones;
        logic [W-1:0] t, ej, ek;

        rst = 1'b1;
        req_valid = 1'b0;
        req_target = '0;
        load = 1'b0;
        load_val = '0;
        stuck = '0;
        #1;
        check("rst_en", en, 1'b0);
        check("rst_jk", {j, k}, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_match_err", {match, err_mask}, 5'h0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        @(posedge clk); #1;
        preset_q(4'b0101);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic drive: Q=0101 -> 0011
        run_req("basic", 4'b0011, 4'b0010, 4'b0100, 4, 1, 1'b1, 4'b0000, -1);

        // Target already equal to Q
        preset_q(4'b1010);
        run_req("same", 4'b1010, 4'b0000, 4'b0000, 4, 1, 1'b1, 4'b0000, -1);

        // Stuck-at-0 bit 0
        preset_q(4'b0000);
        stuck = 4'b0001;
`ifdef JK_DRV_RETRY_EN
        run_req("stuck", 4'b0001, 4'b0001, 4'b0000, 12, 3, 1'b0, 4'b0001, -1);
        preset_q(4'b0000);
        run_req("unstick", 4'b0001, 4'b0001, 4'b0000, 8, 2, 1'b1, 4'b0000, 4);
`else
        run_req("stuck", 4'b0001, 4'b0001, 4'b0000, 4, 1, 1'b0, 4'b0001, -1);
`endif
        stuck = '0;

        // Reset during DRIVE: en and j drop without a clock edge
        preset_q(4'b0000);
        req_valid = 1'b1;
        req_target = 4'b1100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rdrv_en_pre", en, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rdrv_en", en, 1'b0);
        check("rdrv_jk", {j, k}, 8'h00);
        check("rdrv_ready", req_ready, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-SETTLE, then confirm the abandoned request never reports
        req_valid = 1'b1;
        req_target = 4'b0110;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rset_state_pre", state_dbg, 2'd2);
        #2 rst = 1'b1;
        #1;
        check("rset_en_jk_done", {en, j, k, done}, 10'h0);
        check("rset_state", state_dbg, 2'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("rset_no_done", dones, 0);
        check("rset_ready", req_ready, 1'b1);

        // Back-to-back: valid held high, new target presented on done cycle
        preset_q(4'b0000);
        req_valid = 1'b1;
        req_target = 4'b0110;
        @(posedge clk); #1;
        wait_done(lat, pul, -1);
        check("b2b_lat", lat, 4);
        check("b2b_match", match, 1'b1);
        req_target = 4'b1001;
        @(posedge clk); #1;
        check("b2b_en", en, 1'b1);
        check("b2b_j", j, 4'b1001);
        check("b2b_k", k, 4'b0110);

        // 200 random back-to-back targets
        for (int i = 0; i < 200; i++) begin
            wait_done(lat, pul, -1);
            check("rnd_lat", lat, 4);
            check("rnd_match", match, 1'b1);
            t = 4'($urandom_range(0, 15));
            ej = ~q_fb & t;
            ek = q_fb & ~t;
            req_target = t;
            @(posedge clk); #1;
            check("rnd_en", en, 1'b1);
            check("rnd_j", j, ej);
            check("rnd_k", k, ek);
            check("rnd_no_toggle", j & k, 4'b0000);
        end
        wait_done(lat, pul, -1);
        req_valid = 1'b0;
        check("rnd_last_match", match, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
